// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers.
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH = 4;
    localparam int unsigned PTR_WIDTH       = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned DEPTH           = 2 ** FIFO_ADDR_WIDTH;
    localparam int unsigned GRAY_FN_WIDTH   = 32;

    // Binary to gray on a wide word; callers zero-extend and truncate to their width.
    function automatic logic [GRAY_FN_WIDTH-1:0] bin2gray(input logic [GRAY_FN_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Mask that flips the two MSBs of a gray pointer of width ptr_w (full comparison).
    function automatic logic [GRAY_FN_WIDTH-1:0] full_mask(input int unsigned ptr_w);
        return GRAY_FN_WIDTH'(3) << (ptr_w - 2);
    endfunction

    localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(full_mask(PTR_WIDTH));

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-code to binary converter, shared by both pointer controllers.
module gray2bin #(
    parameter int unsigned DATA_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0] gray_i,
    output logic [DATA_WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all gray bits at or above its position.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller of the async FIFO (write clock domain only).
module fifo_wr_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   wr_level
);

    localparam int unsigned PTR_W    = ADDR_WIDTH + 1;
    localparam int unsigned WR_DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned AF_LEVEL = WR_DEPTH - AFULL_THRESH;
    localparam logic [PTR_W-1:0] MASK = PTR_W'(full_mask(PTR_W));

    logic [PTR_W-1:0] sync_q [SYNC_STAGES];
    logic [PTR_W-1:0] sync_d [SYNC_STAGES];
    logic [PTR_W-1:0] rsync;
    logic [PTR_W-1:0] rbin;

    logic [PTR_W-1:0] wbin_q,  wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q,  full_d;
    logic             afull_q, afull_d;
    logic             ovf_q,   ovf_d;

    assign rsync = sync_q[SYNC_STAGES-1];

    gray2bin #(
        .DATA_WIDTH (PTR_W)
    ) u_rd_gray2bin (
        .gray_i (rsync),
        .bin_o  (rbin)
    );

    // Accept decision, next pointer and the flags derived from it.
    always_comb begin
        wr_ack  = wr_req & ~full_q & ~rst;
        wbin_d  = wbin_q + PTR_W'(wr_ack);
        wgray_d = PTR_W'(bin2gray(GRAY_FN_WIDTH'(wbin_d)));
        level_d = wbin_d - rbin;
        full_d  = (wgray_d == (rsync ^ MASK));
        afull_d = (level_d >= PTR_W'(AF_LEVEL));
        ovf_d   = wr_req & full_q;
    end

    // Read-pointer synchronizer shift register; no logic between stages.
    always_comb begin
        sync_d[0] = rd_ptr_gray_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign wr_addr     = wbin_q[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = wgray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;
    assign wr_level    = level_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Scoreboard bench for fifo_wr_ptr_ctrl against an occupancy-count reference model.
module tb_fifo_wr_ptr_ctrl;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int SYNC  = 2;
    localparam int AFT   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic          wr_ack;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_ptr_gray;
    logic [PW-1:0] rd_ptr_gray_async;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic [PW-1:0] wr_level;

    always #5 clk = ~clk;

    fifo_wr_ptr_ctrl #(
        .ADDR_WIDTH   (AW),
        .SYNC_STAGES  (SYNC),
        .AFULL_THRESH (AFT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wr_req            (wr_req),
        .wr_ack            (wr_ack),
        .wr_addr           (wr_addr),
        .wr_ptr_gray       (wr_ptr_gray),
        .rd_ptr_gray_async (rd_ptr_gray_async),
        .full              (full),
        .almost_full       (almost_full),
        .overflow          (overflow),
        .wr_level          (wr_level)
    );

    typedef struct {
        logic          ack;
        logic [AW-1:0] addr;
        logic [PW-1:0] gray;
        logic          full;
        logic          af;
        logic          ovf;
        logic [PW-1:0] level;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: write count, seen-read count delayed by the synchronizer.
    int   m_w;
    int   m_level;
    bit   m_full;
    bit   m_af;
    bit   m_ovf;
    int   dl[$];
    int   rptr;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) % PMOD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
        dl.delete();
        repeat (SYNC) dl.push_back(0);
    endtask

    // One clock cycle of stimulus; the expected view for this cycle goes to the scoreboard.
    task automatic step(input bit r, input bit q, input int rp);
        exp_t e;
        int   rs;
        int   w_n;
        bit   ack;
        @(posedge clk);
        #1;
        rst               = r;
        wr_req            = q;
        rd_ptr_gray_async = PW'(to_gray(rp));
        ack     = q && !m_full && !r;
        e.ack   = ack;
        e.addr  = AW'(m_w);
        e.gray  = PW'(to_gray(m_w));
        e.full  = m_full;
        e.af    = m_af;
        e.ovf   = m_ovf;
        e.level = PW'(m_level);
        sb.push_back(e);
        rs = dl.pop_front();
        if (r) begin
            model_reset();
        end else begin
            w_n     = (m_w + (ack ? 1 : 0)) % PMOD;
            m_ovf   = q && m_full;
            m_w     = w_n;
            m_level = (w_n - rs + PMOD) % PMOD;
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= DEPTH - AFT);
            dl.push_back(rp);
        end
    endtask

    // Monitor: compare what the DUT presents each cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_ack",      32'(wr_ack),      32'(e.ack));
            chk("wr_addr",     32'(wr_addr),     32'(e.addr));
            chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(e.gray));
            chk("full",        32'(full),        32'(e.full));
            chk("almost_full", 32'(almost_full), 32'(e.af));
            chk("overflow",    32'(overflow),    32'(e.ovf));
            chk("wr_level",    32'(wr_level),    32'(e.level));
        end
    end

    initial begin
        rst = 1'b1; wr_req = 1'b0; rd_ptr_gray_async = '0;
        rptr = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset held with a pending request.
        repeat (3) step(1, 1, 0);

        // Fill from empty and keep requesting into full.
        repeat (20) step(0, 1, 0);

        // Release: read pointer jumps to 4, then resume writing.
        rptr = 4;
        repeat (4) step(0, 0, rptr);
        repeat (6) step(0, 1, rptr);

        // Randomized traffic; reader never passes the writer.
        for (int c = 0; c < 1500; c++) begin
            bit r;
            bit q;
            r = ($urandom_range(0, 199) == 0);
            q = ($urandom_range(0, 3) != 0);
            if (((m_w - rptr + PMOD) % PMOD) != 0 && $urandom_range(0, 2) == 0)
                rptr = (rptr + 1) % PMOD;
            step(r, q, rptr);
            if (r) rptr = 0;
        end

        // Reset pulse at level 9, then restart writing.
        step(1, 0, 0);
        rptr = 0;
        repeat (9) step(0, 1, 0);
        step(1, 1, 0);
        repeat (5) step(0, 1, 0);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
Name: fifo_wr_ptr_ctrl

Overview:
Write-side pointer controller for the async FIFO.
- Accepts write requests and generates the memory write address.
- Maintains the binary write pointer and its registered gray-coded copy, which is exported to the read domain.
- Synchronizes the read domain's gray pointer and derives full, almost_full, overflow and fill level.
- Sits between the write client and the dual-port RAM, all in the write clock domain.

Parameters:
ADDR_WIDTH, 4, RAM address bits; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
SYNC_STAGES, 2, flop stages on rd_ptr_gray_async (legal values 2..4)
AFULL_THRESH, 2, almost_full asserts when level >= DEPTH - AFULL_THRESH (legal values 1..DEPTH-1)

Ports:
clk  input  1  write-domain clock
rst  input  1  synchronous, active-high reset
wr_req  input  1  client write request
wr_ack  output  1  combinational: wr_req & ~full & ~rst; also the RAM write enable
wr_addr  output  ADDR_WIDTH  RAM write address = low bits of binary write pointer
wr_ptr_gray  output  ADDR_WIDTH+1  registered gray write pointer, to read-domain synchronizer
rd_ptr_gray_async  input  ADDR_WIDTH+1  read-domain gray pointer, asynchronous to clk
full  output  1  registered full flag
almost_full  output  1  registered almost-full flag
overflow  output  1  registered one-cycle pulse: wr_req seen while full
wr_level  output  ADDR_WIDTH+1  registered fill level as seen from the write side, 0..DEPTH

Behaviour:
- All state is updated on the rising edge of clk only; there is no asynchronous logic.
- Reset values: wbin=0, wr_ptr_gray=0, all sync stages=0, full=0, almost_full=0, overflow=0, wr_level=0, wr_ack=0.
- Reset taking effect mid-operation clears all state on that edge; in-flight writes are discarded and writing resumes at address 0.
- Synchronizer: rsync is the output of an SYNC_STAGES-deep shift register fed by rd_ptr_gray_async. It receives no other logic.
- rbin is gray2bin(rsync), computed combinationally.
- Next-pointer logic: wbin_next = wbin + wr_ack, modulo 2**(ADDR_WIDTH+1); wgray_next = (wbin_next>>1) ^ wbin_next.
- Registered updates each edge:
  - wbin <= wbin_next
  - wr_ptr_gray <= wgray_next
  - full <= (wgray_next == {~rsync[MSB:MSB-1], rsync[MSB-2:0]})
  - wr_level <= wbin_next - rbin, modulo 2**(ADDR_WIDTH+1)
  - almost_full <= (wbin_next - rbin) >= DEPTH - AFULL_THRESH
  - overflow <= wr_req & full
- Latency:
  - wr_addr and wr_ptr_gray advance on the edge after the accept.
  - full asserts on the same edge as the DEPTH-th accept.
  - Full release is pessimistic: after rd_ptr_gray_async changes, full can deassert no earlier than SYNC_STAGES+1 edges later.
- Full boundary: while full=1, wr_ack=0 and the pointer holds. If full clears on an edge, a wr_req present in the following cycle is accepted.
- Wrap-around: the pointer rolls over from 2**(ADDR_WIDTH+1)-1 to 0. The gray code changes by exactly one bit per accept, including across the rollover.
- Outputs never glitch except wr_ack, which is combinational.
- wr_level never exceeds DEPTH, provided the read side obeys its empty flag.

Decomposition:
- Shared package fifo_pkg:
  - PTR_WIDTH = ADDR_WIDTH+1
  - DEPTH
  - bin-to-gray function (shared by both pointer controllers)
  - full-compare mask constant
- Reuse the team's existing binary-to-gray encoder for wgray_next.
- One new sub-module: gray2bin, parameterized DATA_WIDTH, combinational. The read-side controller reuses it.

Test Plan:
1. Reset test: assert rst for 3 cycles with wr_req=1. Required response: wr_ack=0 and every output 0 throughout; after release, the first accept has wr_addr=0.
2. Fill test: set rd_ptr_gray_async=0 and hold wr_req=1 for 20 cycles. Required response:
   - wr_ack high for exactly 16 cycles, with wr_addr stepping 0..15.
   - wr_ptr_gray sequence 00000, 00001, 00011, 00010, ...
   - almost_full rises at level 14; full rises with the 16th accept; wr_level=16.
   - overflow pulses in cycles 17..20.
3. Release test: from full, drive rd_ptr_gray_async=00110 (read pointer 4). Required response:
   - full falls exactly 3 edges later, and wr_level=12 on that same edge.
   - almost_full=0.
   - The next wr_req is accepted at wr_addr=0.
4. Wrap test: advance the read and write pointers through 31->0. Required response:
   - wr_ptr_gray goes 10000 -> 00000.
   - With wbin=20 (gray 11110) and rsync=00110, full=1.
   - With wbin=19, full=0.
5. Simultaneous test: in the same cycle, full=1, wr_req=1 and the read pointer advances. Required response: no accept until full falls; the accept occurs in the first cycle where full=0; no pointer double-step.
6. Mid-operation reset test: pulse rst for one cycle at level 9. Required response: all outputs are 0 on the next edge; writes restart at wr_addr=0 and wr_ptr_gray=00000.
